// File: rtl/seven_pkg.sv
// Shared constants for the seven-segment capture block.
// Segment patterns are in the active-high segment domain (bit order gfedcba).
// The active-low pin value is inverted before these are used.
package seven_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // The stability counter only ever has to reach STABLE_CYCLES-1 (max 254).
  localparam int CNT_W = 8;

  // WAIT: counting identical samples. HOLD: decoded, waiting for a change.
  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } cap_state_t;

endpackage

// File: rtl/seven_capture_if.sv
// Raw pin bundle sampled from a scanned seven-segment display driver.
//   hg : active-low segments, hgfedcba (h = decimal point)
//   an : active-low digit enables
// master drives the pins, slave samples them.
interface seven_capture_if #(
  parameter int DIGITS = 4
) ();
  logic [7:0]        hg;
  logic [DIGITS-1:0] an;

  modport master (output hg, output an);
  modport slave  (input  hg, input  an);
endinterface

// File: rtl/seven_capture_sync.sv
// Two-flop synchronizer for the asynchronous display pins.
//   clk, rst_n : clock, async active-low reset
//   pins       : raw pin bundle (slave side)
//   hg_s, an_s : synchronized copies, two edges behind the pins
module seven_capture_sync #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seven_capture_if.slave    pins,
  output logic [7:0]        hg_s,
  output logic [DIGITS-1:0] an_s
);

  logic [7:0]        hg_m;
  logic [DIGITS-1:0] an_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hg_m <= '0;
      an_m <= '0;
      hg_s <= '0;
      an_s <= '0;
    end else begin
      hg_m <= pins.hg;
      an_m <= pins.an;
      hg_s <= hg_m;
      an_s <= an_m;
    end
  end

endmodule

// File: rtl/seven_decode.sv
// Combinational segment-pattern to nibble lookup.
//   seg    : active-high segments gfedcba
//   nibble : hex value of the recognized glyph (0 on miss)
//   hit    : seg matched one of the 16 glyphs (blank is a miss)
module seven_decode
  import seven_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_capture.sv
// Captures the digits shown on a multiplexed seven-segment display by
// watching its segment and digit-enable pins.
//   clk_i, rst_n_i : clock, async active-low reset
//   hg_i, an_i     : active-low segment bus and digit enables
//   code_o, dp_o   : captured nibble / decimal point per digit
//   valid_o        : every digit captured at least once since reset
//   frame_o        : pulse when a full set of digits has been captured
//   err_o          : pulse on an unrecognized, non-blank pattern
module seven_capture
  import seven_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [7:0]          hg_i,
  input  logic [DIGITS-1:0]   an_i,
  output logic [4*DIGITS-1:0] code_o,
  output logic [DIGITS-1:0]   dp_o,
  output logic                valid_o,
  output logic                frame_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  seven_capture_if #(.DIGITS(DIGITS)) pin_if ();
  assign pin_if.hg = hg_i;
  assign pin_if.an = an_i;

  logic [7:0]        hg_s, hg_p;
  logic [DIGITS-1:0] an_s, an_p;

  seven_capture_sync #(.DIGITS(DIGITS)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .pins  (pin_if),
    .hg_s  (hg_s),
    .an_s  (an_s)
  );

  // ---- stability FSM ----
  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same, dec_evt;

  assign same = (hg_s == hg_p) && (an_s == an_p);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      hg_p    <= '0;
      an_p    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hg_p    <= hg_s;
      an_p    <= an_s;
    end
  end

  // The decode event is combinational so the write lands on the same edge
  // that would otherwise have advanced the counter past STABLE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_evt = 1'b0;
    if (!same) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else if (state_q == ST_WAIT) begin
      if (cnt_q == CNT_LAST) begin
        dec_evt = 1'b1;
        state_d = ST_HOLD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---- decode ----
  logic [6:0]        seg;
  logic [3:0]        nibble;
  logic              hit, one_en, blank, wr, bad;
  logic [DIGITS-1:0] en;

  assign seg    = ~hg_s[6:0];
  assign en     = ~an_s;
  assign one_en = $onehot(en);
  assign blank  = (seg == SEG_BLANK);
  assign wr     = dec_evt && one_en && hit;
  assign bad    = dec_evt && one_en && !hit && !blank;

  seven_decode u_dec (
    .seg    (seg),
    .nibble (nibble),
    .hit    (hit)
  );

  // ---- capture registers ----
  logic [DIGITS-1:0][3:0] code_q;
  logic [DIGITS-1:0]      seen_q;
  logic                   full;

  assign code_o = code_q;
  assign full   = &seen_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      code_q  <= '0;
      dp_o    <= '0;
      seen_q  <= '0;
      valid_o <= 1'b0;
      frame_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (wr && en[k]) begin
          code_q[k] <= nibble;
          dp_o[k]   <= ~hg_s[7];
        end
      end
      // A full mask is cleared the edge after it fills; a write landing on
      // that same edge counts toward the next frame.
      seen_q  <= (full ? '0 : seen_q) | (wr ? en : '0);
      frame_o <= full;
      err_o   <= bad;
      if (full) valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_capture.sv
module tb_seven_capture;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_capture_if #(.DIGITS(4)) bus  ();
  seven_capture_if #(.DIGITS(1)) bus1 ();

  logic [15:0] code;
  logic [3:0]  dp;
  logic        valid, frame, err;
  logic [3:0]  code1;
  logic        dp1, valid1, frame1, err1;

  seven_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .hg_i(bus.hg), .an_i(bus.an),
    .code_o(code), .dp_o(dp), .valid_o(valid), .frame_o(frame), .err_o(err)
  );

  seven_capture #(.DIGITS(1), .STABLE_CYCLES(2)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .hg_i(bus1.hg), .an_i(bus1.an),
    .code_o(code1), .dp_o(dp1), .valid_o(valid1), .frame_o(frame1), .err_o(err1)
  );

  int frame_cnt = 0, err_cnt = 0, frame1_cnt = 0;
  always @(negedge clk) begin
    if (frame)  frame_cnt++;
    if (err)    err_cnt++;
    if (frame1) frame1_cnt++;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, need %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input logic [6:0] seg, input logic lit);
    return {~lit, ~seg};
  endfunction

  initial begin
    logic [6:0] segs [4];
    int f0, e0;
    segs = '{7'h06, 7'h5B, 7'h4F, 7'h66};

    // reset state
    rst_n = 1'b0; bus.hg = 8'hFF; bus.an = 4'hF; bus1.hg = 8'hFF; bus1.an = 1'b1;
    tick(3);
    chk("rst_code", code, 0);
    chk("rst_dp", dp, 0);
    chk("rst_valid", valid, 0);
    chk("rst_frame", frame, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick(10);

    // single digit 0
    e0 = err_cnt;
    bus.an = 4'b1110; bus.hg = pat(7'h3F, 1'b0);
    tick(6);
    chk("d0_code", code[3:0], 4'h0);
    chk("d0_valid", valid, 0);
    tick(20);
    chk("d0_err", err_cnt - e0, 0);

    // exact latency: 2+STABLE_CYCLES edges after first pin sample
    bus.hg = pat(7'h06, 1'b0);
    tick(6);
    chk("lat_pre", code[3:0], 4'h0);
    tick(1);
    chk("lat_post", code[3:0], 4'h1);
    tick(10);

    // scan all four digits
    f0 = frame_cnt;
    for (int d = 0; d < 4; d++) begin
      bus.an = ~(4'b0001 << d);
      bus.hg = pat(segs[d], d == 2);
      tick(8);
    end
    bus.an = 4'hF;
    tick(4);
    chk("scan_code", code, 16'h4321);
    chk("scan_dp", dp, 4'b0100);
    chk("scan_frame", frame_cnt - f0, 1);
    chk("scan_valid", valid, 1);

    // glitching input never settles
    f0 = frame_cnt; e0 = err_cnt;
    bus.an = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      bus.hg = (i % 2) ? pat(7'h7F, 1'b0) : pat(7'h3F, 1'b0);
      tick(2);
    end
    bus.an = 4'hF;
    tick(10);
    chk("glitch_code", code, 16'h4321);
    chk("glitch_err", err_cnt - e0, 0);
    chk("glitch_frame", frame_cnt - f0, 0);

    // unrecognized pattern
    e0 = err_cnt;
    bus.an = 4'b1110; bus.hg = pat(7'h55, 1'b0);
    tick(20);
    bus.an = 4'hF;
    tick(4);
    chk("bad_err", err_cnt - e0, 1);
    chk("bad_code", code, 16'h4321);

    // blank pattern
    e0 = err_cnt;
    bus.an = 4'b1110; bus.hg = 8'hFF;
    tick(20);
    bus.an = 4'hF;
    tick(4);
    chk("blank_err", err_cnt - e0, 0);
    chk("blank_code", code, 16'h4321);

    // two enables, then none
    e0 = err_cnt;
    bus.an = 4'b1100; bus.hg = pat(7'h7F, 1'b0);
    tick(20);
    chk("multi_code", code, 16'h4321);
    bus.an = 4'b1111;
    tick(20);
    chk("none_code", code, 16'h4321);
    chk("multi_err", err_cnt - e0, 0);

    // reset while counter = 2
    bus.an = 4'b1101; bus.hg = pat(7'h6D, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_code", code, 0);
    chk("mid_rst_dp", dp, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_frame", frame, 0);
    chk("mid_rst_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rel_pre", code[7:4], 4'h0);
    tick(1);
    chk("rel_post", code[7:4], 4'h5);
    bus.an = 4'hF;
    tick(4);

    // single-digit instance: every write closes a frame
    f0 = frame1_cnt;
    bus1.an = 1'b0; bus1.hg = pat(7'h4F, 1'b1);
    tick(8);
    chk("one_code_a", code1, 4'h3);
    chk("one_dp_a", dp1, 1);
    chk("one_frame_a", frame1_cnt - f0, 1);
    chk("one_valid", valid1, 1);
    bus1.hg = pat(7'h07, 1'b0);
    tick(8);
    chk("one_code_b", code1, 4'h7);
    chk("one_dp_b", dp1, 0);
    chk("one_frame_b", frame1_cnt - f0, 2);
    chk("one_err", err1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_capture.md
SEVEN_CAPTURE -- requirements
Module: seven_capture

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of scanned digit positions (1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, consecutive identical synchronized samples required before a decode (2..255).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port hg_i  input  8  active-low segment bus, bit order hgfedcba, h = decimal point.
REQ-006 SHALL have port an_i  input  DIGITS  active-low digit enables from a scanned display driver.
REQ-007 SHALL have port code_o  output  4*DIGITS  captured nibble per digit, digit k at bits [4k+3:4k].
REQ-008 SHALL have port dp_o  output  DIGITS  captured decimal point per digit, 1 = lit.
REQ-009 SHALL have port valid_o  output  1  every digit captured at least once since reset.
REQ-010 SHALL have port frame_o  output  1  one-cycle pulse when all digits have been captured since the last pulse.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on an unrecognized non-blank segment pattern.

Function
REQ-012 SHALL pass hg_i and an_i through a two-flop synchronizer before any other use.
REQ-013 SHALL compare each synchronized {an,hg} sample with the previous one; any difference resets the stability counter to 0 and returns the FSM to WAIT.
REQ-014 FSM states SHALL be WAIT (counting identical samples) and HOLD (decode done, waiting for the input to change).
REQ-015 In WAIT, a match with counter = STABLE_CYCLES-1 SHALL trigger exactly one decode event and move to HOLD; otherwise the counter increments.
REQ-016 In HOLD, identical samples SHALL NOT trigger further decodes; only a change returns to WAIT with counter 0.
REQ-017 A decode event SHALL act only if exactly one an bit is 0; zero or multiple active enables SHALL be ignored silently.
REQ-018 Decode SHALL use seg = ~hg[6:0]: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
REQ-019 On a table hit, the active digit's nibble and dp (~hg[7]) SHALL be written, and its seen bit set, on the edge after the decode event.
REQ-020 seg = 00 (blank) SHALL be ignored: no write, no err_o.
REQ-021 Any other seg value SHALL leave the slot unchanged and pulse err_o for one cycle, coincident with where the write would occur.
REQ-022 Latency: a pin change held constant SHALL appear on code_o/dp_o exactly 2+STABLE_CYCLES rising edges after it is first sampled at the pins.
REQ-023 When a write makes the seen mask all-ones, frame_o SHALL pulse on the next cycle, the seen mask SHALL clear on that same edge, and valid_o SHALL set and remain 1 until reset.
REQ-024 Rewriting an already-seen digit SHALL update its value without affecting frame timing.
REQ-025 DIGITS = 1 SHALL pulse frame_o after every successful write.

Reset
REQ-026 rst_n_i low SHALL asynchronously clear synchronizers, counter, seen mask, code_o, dp_o, valid_o, frame_o, err_o and force the FSM to WAIT.
REQ-027 Reset assertion mid-count or mid-HOLD SHALL abort the pending decode; after release, capture restarts from the synchronizer.

Structure
REQ-028 Segment pattern constants (16 hex patterns, SEG_BLANK = 7'h00) and the FSM state encoding SHALL live in shared package seven_pkg.
REQ-029 Pattern-to-nibble lookup SHALL be a combinational sub-module seven_decode (in: 7-bit seg; out: 4-bit nibble, hit).

Verification
REQ-030 Reset then an_i = 1110, hg_i = ~3F held -> code_o[3:0] = 0 after 6 edges (STABLE_CYCLES = 4), err_o stays 0, valid_o 0.
REQ-031 Scan digits 0..3 with ~06, ~5B, ~4F, ~66 (dp lit on digit 2), 8 cycles each -> code_o = 16'h4321, dp_o = 0100, one frame_o pulse, valid_o = 1.
REQ-032 Glitch: hg_i toggles every 2 cycles for 40 cycles -> no write, no err_o, no frame_o.
REQ-033 an_i = 1110, hg_i = ~7'h55 held 20 cycles -> exactly one err_o pulse, code_o unchanged.
REQ-034 an_i = 1100 or 1111 with a valid pattern held 20 cycles -> no write, no err_o.
REQ-035 rst_n_i pulsed low at counter = 2 -> all outputs 0 immediately; no write for that pattern until 6 edges after release.
